fetch_unit: RTL

- Instruction fetch front end. Produces the in-order instruction stream that the decode stage consumes; the decoder reads inst[6:0] as its opcode.
- Issues word fetches to instruction memory over a valid/ready request channel and accepts in-order responses.
- Buffers fetched words in a small queue and presents them to decode with a valid/ready handshake.
- Flushes the queue and restarts from a new PC when execute signals a taken branch or jump.

---
 rtl/fetch_unit.sv | 81 ++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end with a credit-limited request queue and redirect flush
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [6:0]  opcode
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH = (CW+1)'(QUEUE_DEPTH);
  localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};
  logic [31:0] q_inst [QUEUE_DEPTH];
  logic [31:0] q_pc [QUEUE_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, outstanding_cnt, discard_cnt, outstanding_nxt;
  logic [31:0] fetch_pc, resp_pc, target_pc;
  logic accept, enq, deq;
  // Queue slots and in-flight requests share one credit pool, so a response always has room.
  assign imem_req_valid = !rst && !redirect_valid && (({1'b0, count} + {1'b0, outstanding_cnt}) < DEPTH);
  assign imem_req_addr = fetch_pc;
  assign accept = imem_req_valid && imem_req_ready;
  assign enq = imem_resp_valid && !redirect_valid && discard_cnt == '0;
  assign inst_valid = count != '0;
  assign deq = inst_valid && inst_ready;
  assign inst = inst_valid ? q_inst[rd_ptr] : '0;
  assign inst_pc = inst_valid ? q_pc[rd_ptr] : '0;
  assign opcode = inst[6:0];
  assign outstanding_nxt = outstanding_cnt + CW'(accept) - CW'(imem_resp_valid);
  assign target_pc = {redirect_pc[31:2], 2'b00};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= START_PC;
      resp_pc <= START_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      outstanding_cnt <= '0;
      discard_cnt <= '0;
    end else begin
      outstanding_cnt <= outstanding_nxt;
      if (redirect_valid) begin
        fetch_pc <= target_pc;
        resp_pc <= target_pc;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count <= '0;
        discard_cnt <= outstanding_nxt;
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (enq) resp_pc <= resp_pc + 32'd4;
        if (enq) wr_ptr <= wr_ptr + AW'(1);
        if (deq) rd_ptr <= rd_ptr + AW'(1);
        if (imem_resp_valid && discard_cnt != '0) discard_cnt <= discard_cnt - CW'(1);
        count <= count + CW'(enq) - CW'(deq);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (enq) begin
      q_inst[wr_ptr] <= imem_resp_data;
      q_pc[wr_ptr] <= resp_pc;
    end
  end
  a_resp_has_request: assert property (@(posedge clk) disable iff (rst)
    imem_resp_valid |-> outstanding_cnt != '0);
  a_req_stable: assert property (@(posedge clk) disable iff (rst)
    imem_req_valid && !imem_req_ready |=> redirect_valid || (imem_req_valid && $stable(imem_req_addr)));
endmodule
